// File: rtl/dbg_clk_pkg.sv
// Shared definitions for the debug slow-clock controller.
// Holds the controller state encoding and the default sizes and reset
// divisor used by dbg_clk_ctrl and its half-period counter.
package dbg_clk_pkg;

    localparam int DEFAULT_CNT_W  = 27;
    localparam int DEFAULT_STEP_W = 16;
    // Half-period terminal count giving a 500 Hz output from a 100 MHz clk.
    localparam int DEFAULT_HALF   = 99_999;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STEP     = 2'd2,
        ST_STOPPING = 2'd3
    } state_e;

endpackage

// File: rtl/dbg_half_counter.sv
// Half-period counter for the debug clock divider.
// Counts up while enabled and wraps to zero on the terminal count.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   enable    - count while high (controller not idle)
//   clear     - force the count to zero on the next edge
//   load_val  - terminal count (half-period minus one)
//   count     - current count
//   tc        - terminal count reached this cycle (only while enabled)
module dbg_half_counter #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = enable && (count == load_val);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tc ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dbg_clk_ctrl.sv
// Run/stop/single-step controller for the debug slow-clock divider.
// Owns the toggled output clock, the divisor handshake and the control FSM;
// the half-period counter lives in dbg_half_counter.
// Ports:
//   clk, rst               - system clock, synchronous active-high reset
//   cfg_valid/cfg_half     - offered divisor (half-period = cfg_half+1 cycles)
//   cfg_ready              - divisor slot free
//   cmd_run/stop/step      - one-cycle command pulses (stop > step > run)
//   step_count             - output periods for cmd_step
//   clk_out, tick          - divided clock and its rising-edge pulse
//   busy, state            - controller activity and state encoding
//   tick_cnt               - tick counter, present only with DBG_CLK_CNT_EN
// Optional feature macro: DBG_CLK_CNT_EN.
module dbg_clk_ctrl #(
    parameter int CNT_W        = dbg_clk_pkg::DEFAULT_CNT_W,
    parameter int DEFAULT_HALF = dbg_clk_pkg::DEFAULT_HALF,
    parameter int STEP_W       = dbg_clk_pkg::DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_ready,
    input  logic              cmd_run,
    input  logic              cmd_stop,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_count,
    output logic              clk_out,
    output logic              tick,
    output logic              busy,
    output logic [1:0]        state
`ifdef DBG_CLK_CNT_EN
   ,output logic [31:0]       tick_cnt
`endif
);

    import dbg_clk_pkg::*;

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    state_e              state_q, state_nxt;
    logic [CNT_W-1:0]    half_reg;
    logic [CNT_W-1:0]    pending_half;
    logic                pending_q;
    logic [STEP_W-1:0]   step_rem_q, step_rem_nxt;
    logic                clk_out_nxt;
    logic                tick_nxt;
    logic                tc;
    logic                fall_tc;
    state_e              stop_target;

    dbg_half_counter #(
        .CNT_W (CNT_W)
    ) u_half_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (state_q != ST_IDLE),
        .clear    (state_nxt == ST_IDLE),
        .load_val (half_reg),
        .count    (),
        .tc       (tc)
    );

    // A falling terminal count ends a full output period.
    assign fall_tc = tc && clk_out;

    // A stop while high waits for the falling edge unless it is happening
    // right now; a stop while low can drop straight to IDLE.
    assign stop_target = (clk_out && !fall_tc) ? ST_STOPPING : ST_IDLE;

    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state_q;
        step_rem_nxt = step_rem_q;
        clk_out_nxt  = tc ? !clk_out : clk_out;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_step && step_count != '0) begin
                    state_nxt    = ST_STEP;
                    step_rem_nxt = step_count;
                end else if (cmd_run) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_stop) state_nxt = stop_target;
            end
            ST_STEP: begin
                if (cmd_stop) begin
                    state_nxt = stop_target;
                end else if (fall_tc) begin
                    step_rem_nxt = step_rem_q - STEP_W'(1);
                    if (step_rem_q == STEP_W'(1)) state_nxt = ST_IDLE;
                end
            end
            ST_STOPPING: begin
                if (fall_tc) state_nxt = ST_IDLE;
            end
        endcase

        // Leaving for IDLE never lets a fresh high phase start.
        if (state_nxt == ST_IDLE) begin
            clk_out_nxt  = 1'b0;
            step_rem_nxt = '0;
        end

        tick_nxt = clk_out_nxt && !clk_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_rem_q <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            step_rem_q <= step_rem_nxt;
            clk_out    <= clk_out_nxt;
            tick       <= tick_nxt;
        end
    end

    // Divisor slot: a new value waits in pending_half until it can be applied
    // without shortening a phase (immediately in IDLE, else at a falling TC so
    // the next low phase already uses it).
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= 1'b0;
            pending_half <= '0;
            half_reg     <= HALF_RST;
        end else if (pending_q && (state_q == ST_IDLE || fall_tc)) begin
            pending_q <= 1'b0;
            half_reg  <= pending_half;
        end else if (cfg_valid && !pending_q) begin
            pending_q    <= 1'b1;
            pending_half <= cfg_half;
        end
    end

    assign cfg_ready = !pending_q;
    assign busy      = (state_q != ST_IDLE);
    assign state     = state_q;

`ifdef DBG_CLK_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end
`endif

endmodule
